// File: rtl/led_panel_fb_arbiter.sv
// led_panel_fb_arbiter: frame buffer shared by scan reads, host writes and a clear sequencer.
// Define FB_DOUBLE_BUF_EN for front/back banks swapped on frame_sync.
module led_panel_fb_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              frame_sync,
  input  logic              swap_req,
  output logic              swap_done
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nx;
  logic [3:0] wait_cnt, wait_nx;
  logic wr_fire, rd_grant, starved, rd_zero;
`ifdef FB_DOUBLE_BUF_EN
  localparam int IW = ADDR_W + 1;
  logic front, swap_pending, swap_now;
  logic [IW-1:0] wr_idx, clr_idx, rd_idx;
  assign wr_idx   = {~front, wr_addr};
  assign clr_idx  = {~front, clr_addr};
  assign rd_idx   = {front, rd_addr};
  assign starved  = 1'b0;
  assign rd_zero  = 1'b0;
  assign wr_ready = reset_n && state == IDLE;
  // a swap_req coincident with frame_sync swaps on that same edge
  assign swap_now = frame_sync && (swap_pending || swap_req) && state == IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      front        <= front ^ swap_now;
      swap_pending <= swap_now ? 1'b0 : swap_pending | swap_req;
      swap_done    <= swap_now;
    end
`else
  localparam int IW = ADDR_W;
  logic [IW-1:0] wr_idx, clr_idx, rd_idx;
  logic unused_swap;
  assign wr_idx      = wr_addr;
  assign clr_idx     = clr_addr;
  assign rd_idx      = rd_addr;
  assign starved     = wait_cnt == 4'(MAX_WAIT);
  assign rd_zero     = state == CLEAR;
  assign wr_ready    = reset_n && state == IDLE && (!rd_req || starved);
  assign swap_done   = 1'b0;
  assign unused_swap = frame_sync ^ swap_req;
`endif
  logic [DATA_W-1:0] mem [2**IW];
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_grant = rd_req && !(wr_fire && starved);
  assign clr_busy = state == CLEAR;
  always_comb begin
    state_nx    = state == IDLE ? (clr_req ? CLEAR : IDLE) : (&clr_addr ? IDLE : CLEAR);
    clr_addr_nx = state == CLEAR ? clr_addr + 1'b1 : '0;
    wait_nx     = state == CLEAR ? wait_cnt :
                  (!wr_valid || wr_fire) ? 4'd0 :
                  starved ? wait_cnt : wait_cnt + 4'd1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      clr_addr <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
      wait_cnt <= wait_nx;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < 2**IW; i++) mem[i] <= '0;
    else if (state == CLEAR) mem[clr_idx] <= '0;
    else if (wr_fire) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_grant;
      if (rd_grant) rd_data <= rd_zero ? '0 : mem[rd_idx];
    end
endmodule

// File: tb/tb_led_panel_fb_arbiter.sv
// tb_led_panel_fb_arbiter: directed checks of arbitration, clear, reset and bank swap.
module tb_led_panel_fb_arbiter;
  logic clk = 0, reset_n = 0;
  logic wr_valid = 0, wr_ready, rd_req = 0, rd_ack, clr_req = 0, clr_busy;
  logic frame_sync = 0, swap_req = 0, swap_done;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0, rd_data;
  int n_vec = 0, n_err = 0;

  led_panel_fb_arbiter dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .clr_req(clr_req), .clr_busy(clr_busy),
    .frame_sync(frame_sync), .swap_req(swap_req), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    int k = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && k < 20) begin @(negedge clk); #1; k++; end
    if (k == 20) begin
      n_vec++; n_err++;
      $display("FAIL write_timeout addr=%0d got wr_ready=0 expected 1", a);
    end
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic ack, output logic [7:0] d);
    rd_req = 1; rd_addr = a;
    @(negedge clk);
    rd_req = 0;
    ack = rd_ack; d = rd_data;
  endtask

  task automatic test_reset;
    wr_valid = 1; rd_req = 1;
    #1;
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got %b expected 0", wr_ready); end
    n_vec++; if (rd_ack !== 1'b0) begin n_err++; $display("FAIL reset_rd_ack got %b expected 0", rd_ack); end
    n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h expected 00", rd_data); end
    n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_clr_busy got %b expected 0", clr_busy); end
    n_vec++; if (swap_done !== 1'b0) begin n_err++; $display("FAIL reset_swap_done got %b expected 0", swap_done); end
    @(negedge clk);
    reset_n = 1; wr_valid = 0; rd_req = 0;
    @(negedge clk);
  endtask

  task automatic test_read_after_reset;
    logic ack; logic [7:0] d;
    do_read(4'd5, ack, d);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL rd5_ack got %b expected 1", ack); end
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rd5_data got %h expected 00", d); end
  endtask

  task automatic test_write;
    logic ack; logic [7:0] d;
    wr_valid = 1; wr_addr = 4'd3; wr_data = 8'hA5;
    #1;
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_idle got %b expected 1", wr_ready); end
    @(negedge clk);
    wr_valid = 0;
    do_read(4'd3, ack, d);
    n_vec++; if (ack !== 1'b1 || d !== 8'hA5) begin n_err++; $display("FAIL rd3 got ack=%b data=%h expected ack=1 data=a5", ack, d); end
  endtask

  task automatic test_starve;
    logic ack; logic [7:0] d;
    do_write(4'd7, 8'h5A);
    rd_req = 1; rd_addr = 4'd3; wr_valid = 1; wr_addr = 4'd7; wr_data = 8'hC3;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++;
      if (wr_ready !== (c == 3)) begin n_err++; $display("FAIL starve_wr_ready c=%0d got %b expected %b", c, wr_ready, c == 3); end
      if (c > 0) begin
        n_vec++;
        if (rd_ack !== (c != 4)) begin n_err++; $display("FAIL starve_rd_ack c=%0d got %b expected %b", c, rd_ack, c != 4); end
      end
      if (c == 1) begin
        n_vec++;
        if (rd_data !== 8'hA5) begin n_err++; $display("FAIL starve_rd_data got %h expected a5", rd_data); end
      end
      if (c == 4) wr_valid = 0;
      @(negedge clk);
    end
    rd_req = 0;
    do_read(4'd7, ack, d);
    n_vec++; if (d !== 8'hC3) begin n_err++; $display("FAIL starved_write_data got %h expected c3", d); end
  endtask

  task automatic test_clear;
    logic ack; logic [7:0] d;
    int busy_cnt = 0;
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'hFF);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    for (int n = 1; n <= 17; n++) begin
      clr_req  = (n == 5);
      wr_valid = (n <= 16); wr_addr = 4'd1; wr_data = 8'hEE;
      rd_req   = (n <= 16); rd_addr = 4'(n);
      #1;
      if (clr_busy) busy_cnt++;
      n_vec++;
      if (clr_busy !== (n <= 16)) begin n_err++; $display("FAIL clr_busy n=%0d got %b expected %b", n, clr_busy, n <= 16); end
      if (n <= 16) begin
        n_vec++;
        if (wr_ready !== 1'b0) begin n_err++; $display("FAIL clr_wr_ready n=%0d got %b expected 0", n, wr_ready); end
      end
      if (n >= 2) begin
        n_vec++;
        if (rd_ack !== 1'b1 || rd_data !== 8'h00) begin n_err++; $display("FAIL clr_read n=%0d got ack=%b data=%h expected ack=1 data=00", n, rd_ack, rd_data); end
      end
      @(negedge clk);
    end
    clr_req = 0; wr_valid = 0; rd_req = 0;
    n_vec++; if (busy_cnt != 16) begin n_err++; $display("FAIL clr_busy_len got %0d expected 16", busy_cnt); end
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), ack, d);
      n_vec++;
      if (d !== 8'h00) begin n_err++; $display("FAIL post_clr addr=%0d got %h expected 00", a, d); end
    end
  endtask

  task automatic test_clr_with_write;
    logic ack; logic [7:0] d;
    int k = 0;
    wr_valid = 1; wr_addr = 4'd2; wr_data = 8'h77; clr_req = 1;
    #1;
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL clr_wr_same_cycle got %b expected 1", wr_ready); end
    @(negedge clk);
    wr_valid = 0; clr_req = 0;
    #1;
    n_vec++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL clr_start got %b expected 1", clr_busy); end
    while (clr_busy && k < 40) begin @(negedge clk); #1; k++; end
    n_vec++; if (k != 16) begin n_err++; $display("FAIL clr_len2 got %0d expected 16", k); end
    do_read(4'd2, ack, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL clr_overwrites_write got %h expected 00", d); end
  endtask

  task automatic test_reset_mid;
    logic ack; logic [7:0] d;
    do_write(4'd9, 8'hC3);
    rd_req = 1; rd_addr = 4'd9; wr_valid = 1; wr_addr = 4'd10; wr_data = 8'h44;
    @(negedge clk);
    n_vec++; if (rd_data !== 8'hC3) begin n_err++; $display("FAIL pre_reset_rd got %h expected c3", rd_data); end
    #2 reset_n = 0;
    #1;
    n_vec++; if (rd_ack !== 1'b0 || rd_data !== 8'h00 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL async_reset_wr got ack=%b data=%h rdy=%b expected 0 00 0", rd_ack, rd_data, wr_ready);
    end
    @(negedge clk);
    reset_n = 1; rd_req = 0; wr_valid = 0;
    do_read(4'd9, ack, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_zeroes_mem got %h expected 00", d); end
    do_write(4'd4, 8'h11);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_vec++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL mid_clr_busy got %b expected 1", clr_busy); end
    reset_n = 0;
    #1;
    n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL async_reset_clr got %b expected 0", clr_busy); end
    @(negedge clk);
    reset_n = 1;
    #1;
    n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got %b expected 0", clr_busy); end
    @(negedge clk);
    do_read(4'd4, ack, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_mid_clr addr4 got %h expected 00", d); end
    do_read(4'd15, ack, d);
    n_vec++; if (ack !== 1'b1 || d !== 8'h00) begin n_err++; $display("FAIL reset_mid_clr addr15 got ack=%b data=%h expected 1 00", ack, d); end
  endtask

  task automatic test_swap;
    logic ack; logic [7:0] d;
`ifdef FB_DOUBLE_BUF_EN
    do_write(4'd0, 8'h3C);
    swap_req = 1;
    @(negedge clk);
    swap_req = 0;
    do_read(4'd0, ack, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL pre_swap_read got %h expected 00", d); end
    repeat (8) @(negedge clk);
    frame_sync = 1;
    #1;
    n_vec++; if (swap_done !== 1'b0) begin n_err++; $display("FAIL swap_early got %b expected 0", swap_done); end
    @(negedge clk);
    frame_sync = 0;
    #1;
    n_vec++; if (swap_done !== 1'b1) begin n_err++; $display("FAIL swap_done got %b expected 1", swap_done); end
    @(negedge clk);
    n_vec++; if (swap_done !== 1'b0) begin n_err++; $display("FAIL swap_pulse_len got %b expected 0", swap_done); end
    do_read(4'd0, ack, d);
    n_vec++; if (ack !== 1'b1 || d !== 8'h3C) begin n_err++; $display("FAIL post_swap_read got ack=%b data=%h expected 1 3c", ack, d); end
`else
    swap_req = 1; frame_sync = 1;
    @(negedge clk);
    swap_req = 0; frame_sync = 0;
    #1;
    n_vec++; if (swap_done !== 1'b0) begin n_err++; $display("FAIL swap_single_bank got %b expected 0", swap_done); end
    do_read(4'd6, ack, d);
    n_vec++; if (ack !== 1'b1 || d !== 8'h00) begin n_err++; $display("FAIL swap_single_read got ack=%b data=%h expected 1 00", ack, d); end
`endif
  endtask

  initial begin
    test_reset;
    test_read_after_reset;
`ifndef FB_DOUBLE_BUF_EN
    test_write;
    test_starve;
    test_clear;
    test_clr_with_write;
    test_reset_mid;
`endif
    test_swap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
